tcam_ctrl: RTL and testbench
============================

# tcam_ctrl

Access scheduler in front of the 16-entry TCAM. Shares the TCAM's single wr/addr/data port between an update requester (entry writes) and a lookup requester (key searches), with valid/ready handshakes on both. Captures the TCAM's two match outputs into a held result. Optionally sweeps every entry to a clear word after reset.

## Interface
- DATA_W, 10, TCAM entry/key width
- ADDR_W, 4, TCAM entry index width (2^ADDR_W entries)
- RES_W, 7, width of each TCAM match output
- SRCH_LAT, 1, TCAM clock edges from key applied to match outputs valid (≥1)
- MAX_WAIT, 4, consecutive lost lookup arbitrations before lookup is forced to win (≥1)
- CLEAR_WORD, 0, data written to every entry by the flush sweep
---
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- upd_valid / upd_ready  in / out  1 / 1  update handshake
- upd_addr  in  ADDR_W  entry to write
- upd_data  in  DATA_W  entry contents
- lkp_valid / lkp_ready  in / out  1 / 1  lookup handshake
- lkp_key  in  DATA_W  search key
- res_valid / res_ready  out / in  1 / 1  result handshake
- res_addr0, res_addr1  out  RES_W  captured TCAM match outputs
- busy  out  1  high whenever state ≠ IDLE
- tcam_wr  out  1  TCAM write enable
- tcam_addr  out  ADDR_W  TCAM entry index
- tcam_data  out  DATA_W  TCAM write data / search key
- tcam_r_addr0, tcam_r_addr1  in  RES_W  TCAM match outputs

## Operation
- States: FLUSH, IDLE, WRITE, SEARCH, RESP.
- Reset (reset=0): every output 0; state ← FLUSH if flush compiled in, else IDLE; flush counter, skip counter and result registers cleared.
- FLUSH: tcam_wr=1, tcam_data=CLEAR_WORD, tcam_addr counts 0..2^ADDR_W−1, one entry per cycle, then IDLE. Both readies 0.
- IDLE: tcam_wr=0; tcam_addr/tcam_data hold their last values. Exactly one ready is high, chosen combinationally:
  - only one valid → that requester;
  - both valid → update, unless skip count = MAX_WAIT, then lookup;
  - neither valid → upd_ready=1.
- Skip counter: +1 when both valid and update accepted; cleared on lookup accept; saturates at MAX_WAIT.
- Update accept (upd_valid & upd_ready at edge) → WRITE for one cycle: tcam_wr=1, tcam_addr=upd_addr, tcam_data=upd_data; then IDLE.
- Lookup accept → SEARCH for SRCH_LAT+1 cycles: tcam_wr=0, tcam_data=key, held constant. At the final SEARCH edge, tcam_r_addr0/1 → res_addr0/1, res_valid←1, state → RESP.
- RESP: res_valid=1, res_addr0/1 stable until res_valid & res_ready at an edge; then res_valid←0 and state → IDLE. Both readies 0 in RESP.
- One TCAM operation outstanding at a time. A write and a search never overlap, so a lookup issued after an update always sees the new entry.

## Timing
- Accept at edge E0.
- Update: tcam_wr high for cycle E0..E0+1; next accept is possible at E0+2. Peak update rate is 1 per 2 cycles.
- Lookup: res_valid rises after edge E0+SRCH_LAT+1. With res_ready tied high, the next accept is possible at E0+SRCH_LAT+3.
- Flush: 2^ADDR_W cycles; busy falls after the last flush write.
- Reset mid-operation: abandons the operation immediately (asynchronous). tcam_wr and res_valid drop at once, no result is produced, and the flush restarts if compiled in.
- Valid deasserted while ready high: no transfer. Inputs are sampled only at the accept edge.

## Configuration
- TCAM_CTRL_FLUSH_EN defined: FLUSH state present; reset enters FLUSH; busy is high for the first 2^ADDR_W cycles after reset release.
- Not defined: FLUSH state, flush counter and CLEAR_WORD logic are absent. Reset enters IDLE; upd_ready=1 on the first cycle after reset release.

## Test plan
- Flush (macro on): release reset → 16 consecutive cycles with tcam_wr=1, tcam_addr 0..15, tcam_data=0; then busy=0 and upd_ready=1.
- Write: upd_addr=4, upd_data=10'b0001001100 accepted at E0 → during E0..E0+1, tcam_wr=1, tcam_addr=4, tcam_data=0x04C; tcam_wr=0 afterwards.
- Lookup with backpressure: key 0x04C; TCAM model returns r_addr0=7'd4, r_addr1=7'd0 one edge after key (SRCH_LAT=1). Response: res_valid rises after E0+2 with res_addr0=4; res_ready held 0 for 3 cycles → res_valid and res_addr0 stay stable, both readies 0.
- Arbitration (MAX_WAIT=4): both valid continuously → accept order U,U,U,U,L,U,U,U,U,L.
- Reset during SEARCH: reset=0 at cycle E0+1 → tcam_wr=0, res_valid=0, no result delivered. Reset released → flush restarts from addr 0.
- Macro off: release reset → no flush writes. An update presented at release is accepted at the first edge, with busy=0 beforehand.

Source files
------------

// File: rtl/tcam_ctrl.sv
// ---------------------------------------------------------------------------
// tcam_ctrl -- access scheduler for a 16-entry TCAM
//
// Purpose:
//   The TCAM has one write/search port: wr/addr/data. This block shares that
//   port between two requesters:
//     - an update requester, which writes entries;
//     - a lookup requester, which searches keys.
//   Only one TCAM operation is in flight at a time. Because of this, a lookup
//   accepted after an update always sees the updated entry. The two TCAM match
//   outputs are captured and held behind a valid/ready result handshake.
//
// Optional feature (compile-time macro TCAM_CTRL_FLUSH_EN):
//   When defined, the controller sweeps CLEAR_WORD into every entry after
//   reset. The sweep takes 2^ADDR_W cycles. When undefined, the controller
//   comes out of reset directly in IDLE.
//
// Ports:
//   clk                         rising-edge clock
//   reset                       asynchronous, active-low reset
//   upd_valid/upd_ready         update handshake
//   upd_addr, upd_data          entry index and entry contents to write
//   lkp_valid/lkp_ready         lookup handshake
//   lkp_key                     key to search for
//   res_valid/res_ready         result handshake
//   res_addr0, res_addr1        captured TCAM match outputs
//   busy                        high whenever the controller is not idle
//   tcam_wr                     TCAM write enable
//   tcam_addr, tcam_data        TCAM entry index and write data / search key
//   tcam_r_addr0, tcam_r_addr1  TCAM match outputs
// ---------------------------------------------------------------------------
module tcam_ctrl #(
    parameter int                DATA_W     = 10,
    parameter int                ADDR_W     = 4,
    parameter int                RES_W      = 7,
    parameter int                SRCH_LAT   = 1,
    parameter int                MAX_WAIT   = 4,
    parameter logic [DATA_W-1:0] CLEAR_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [DATA_W-1:0] upd_data,
    input  logic              lkp_valid,
    output logic              lkp_ready,
    input  logic [DATA_W-1:0] lkp_key,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_addr0,
    output logic [RES_W-1:0]  res_addr1,
    output logic              busy,
    output logic              tcam_wr,
    output logic [ADDR_W-1:0] tcam_addr,
    output logic [DATA_W-1:0] tcam_data,
    input  logic [RES_W-1:0]  tcam_r_addr0,
    input  logic [RES_W-1:0]  tcam_r_addr1
);

    localparam int SKIP_W = $clog2(MAX_WAIT + 1);
    localparam int LAT_W  = (SRCH_LAT < 1) ? 1 : $clog2(SRCH_LAT + 1);

    localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(MAX_WAIT);
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(SRCH_LAT);
    localparam logic [ADDR_W-1:0] ADDR_TOP = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        SEARCH = 3'd2,
        RESP   = 3'd3
`ifdef TCAM_CTRL_FLUSH_EN
        ,
        FLUSH  = 3'd4
`endif
    } state_t;

`ifdef TCAM_CTRL_FLUSH_EN
    localparam state_t RESET_STATE = FLUSH;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t              state_q;
    state_t              state_d;

    // addr_q drives tcam_addr. During the flush sweep it also serves as the
    // sweep index.
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [SKIP_W-1:0]   skip_q;
    logic [LAT_W-1:0]    lat_q;
    logic [RES_W-1:0]    res0_q;
    logic [RES_W-1:0]    res1_q;

    logic                upd_ready_c;
    logic                lkp_ready_c;
    logic                wr_c;
    logic                busy_c;
    logic [DATA_W-1:0]   data_c;
    logic                lkp_pri;
    logic                lat_done;
    logic                upd_acc;
    logic                lkp_acc;

    // Skip count saturates at the limit: once lookup has lost MAX_WAIT times
    // in a row, it keeps priority until it is served.
    function automatic logic [SKIP_W-1:0] sat_inc(input logic [SKIP_W-1:0] cnt);
        if (cnt == SKIP_MAX) begin
            return cnt;
        end
        return cnt + SKIP_W'(1);
    endfunction

    assign lkp_pri  = (skip_q == SKIP_MAX);
    assign lat_done = (lat_q == LAT_LAST);
    assign upd_acc  = upd_valid & upd_ready_c;
    assign lkp_acc  = lkp_valid & lkp_ready_c;

    // Next state and per-state port controls
    always_comb begin
        state_d     = state_q;
        upd_ready_c = 1'b0;
        lkp_ready_c = 1'b0;
        wr_c        = 1'b0;
        busy_c      = 1'b1;
        data_c      = data_q;
        case (state_q)
            IDLE: begin
                busy_c = 1'b0;
                // Exactly one ready is high. Update is the default winner, and
                // it also owns ready when nobody is asking.
                lkp_ready_c = lkp_valid & (~upd_valid | lkp_pri);
                upd_ready_c = ~lkp_ready_c;
                if (upd_valid & upd_ready_c) begin
                    state_d = WRITE;
                end else if (lkp_valid & lkp_ready_c) begin
                    state_d = SEARCH;
                end
            end
            WRITE: begin
                wr_c    = 1'b1;
                state_d = IDLE;
            end
            SEARCH: begin
                if (lat_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
`ifdef TCAM_CTRL_FLUSH_EN
            FLUSH: begin
                wr_c   = 1'b1;
                data_c = CLEAR_WORD;
                if (addr_q == ADDR_TOP) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand, arbitration and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            data_q <= '0;
            skip_q <= '0;
            lat_q  <= '0;
            res0_q <= '0;
            res1_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (upd_acc) begin
                        addr_q <= upd_addr;
                        data_q <= upd_data;
                        if (lkp_valid) begin
                            skip_q <= sat_inc(skip_q);
                        end
                    end else if (lkp_acc) begin
                        data_q <= lkp_key;
                        lat_q  <= '0;
                        skip_q <= '0;
                    end
                end
                SEARCH: begin
                    // The key has been on the port for SRCH_LAT edges by now,
                    // so the match outputs are valid at this edge.
                    if (lat_done) begin
                        res0_q <= tcam_r_addr0;
                        res1_q <= tcam_r_addr1;
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
`ifdef TCAM_CTRL_FLUSH_EN
                FLUSH: begin
                    // Keep the last swept index and word on the port afterwards.
                    data_q <= CLEAR_WORD;
                    if (addr_q != ADDR_TOP) begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

`ifndef TCAM_CTRL_FLUSH_EN
    // CLEAR_WORD only feeds the flush sweep. Reference it here so the
    // parameter stays in the interface of both builds.
    logic unused_clear;
    assign unused_clear = ^CLEAR_WORD;
`endif

    // Everything driven from the state decode is forced low while reset is
    // asserted, even when the reset state is FLUSH.
    assign upd_ready = reset & upd_ready_c;
    assign lkp_ready = reset & lkp_ready_c;
    assign tcam_wr   = reset & wr_c;
    assign busy      = reset & busy_c;
    assign tcam_data = reset ? data_c : '0;
    assign tcam_addr = addr_q;
    assign res_valid = (state_q == RESP);
    assign res_addr0 = res0_q;
    assign res_addr1 = res1_q;

endmodule

// File: tb/tb_tcam_ctrl.sv
module tb_tcam_ctrl;

    localparam int DATA_W   = 10;
    localparam int ADDR_W   = 4;
    localparam int RES_W    = 7;
    localparam int SRCH_LAT = 1;
    localparam int MAX_WAIT = 4;
    localparam int NENT     = 1 << ADDR_W;
    localparam logic [RES_W-1:0] NO_HIT = {RES_W{1'b1}};

    logic              clk       = 1'b0;
    logic              reset     = 1'b0;
    logic              upd_valid = 1'b0;
    logic              upd_ready;
    logic [ADDR_W-1:0] upd_addr  = '0;
    logic [DATA_W-1:0] upd_data  = '0;
    logic              lkp_valid = 1'b0;
    logic              lkp_ready;
    logic [DATA_W-1:0] lkp_key   = '0;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [RES_W-1:0]  res_addr0;
    logic [RES_W-1:0]  res_addr1;
    logic              busy;
    logic              tcam_wr;
    logic [ADDR_W-1:0] tcam_addr;
    logic [DATA_W-1:0] tcam_data;
    logic [RES_W-1:0]  m_r0;
    logic [RES_W-1:0]  m_r1;

    tcam_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RES_W(RES_W),
        .SRCH_LAT(SRCH_LAT), .MAX_WAIT(MAX_WAIT), .CLEAR_WORD('0)
    ) dut (
        .clk(clk), .reset(reset),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_addr(upd_addr), .upd_data(upd_data),
        .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_key(lkp_key),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_addr0(res_addr0), .res_addr1(res_addr1),
        .busy(busy), .tcam_wr(tcam_wr), .tcam_addr(tcam_addr), .tcam_data(tcam_data),
        .tcam_r_addr0(m_r0), .tcam_r_addr1(m_r1)
    );

    always #5 clk = ~clk;

    // TCAM model: exact-match search. r0 is the lowest matching entry index,
    // or all-ones when no entry matches. r1 is the second matching entry
    // index, or 0 when there is no second match. Both are registered one edge
    // after the key (SRCH_LAT = 1).
    logic [DATA_W-1:0] mem [NENT];
    logic              init_mem = 1'b1;

    function automatic logic [2*RES_W-1:0] search(input logic [DATA_W-1:0] k);
        logic [RES_W-1:0] a0;
        logic [RES_W-1:0] a1;
        bit f0;
        bit f1;
        a0 = NO_HIT;
        a1 = '0;
        f0 = 1'b0;
        f1 = 1'b0;
        for (int i = 0; i < NENT; i++) begin
            if (mem[i] == k) begin
                if (!f0) begin
                    a0 = RES_W'(i);
                    f0 = 1'b1;
                end else if (!f1) begin
                    a1 = RES_W'(i);
                    f1 = 1'b1;
                end
            end
        end
        return {a0, a1};
    endfunction

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < NENT; i++) mem[i] <= '0;
        end else if (tcam_wr) begin
            mem[tcam_addr] <= tcam_data;
        end
        {m_r0, m_r1} <= search(tcam_data);
    end

    // Scoreboard and accounting
    typedef struct packed {
        logic [RES_W-1:0] r0;
        logic [RES_W-1:0] r1;
    } res_t;

    res_t             exp_q[$];
    bit               acc_log[$];   // 0 = update accepted, 1 = lookup accepted
    bit               arb_on = 1'b0;
    logic [RES_W-1:0] cur_exp0 = '0;
    logic [RES_W-1:0] cur_exp1 = '0;
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bounded wait expired (t=%0t)", name, $time);
    endtask

    // Monitor: samples on the falling edge. A handshake seen here completes at
    // the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            chk("one_ready_idle", {31'd0, upd_ready} + {31'd0, lkp_ready}, 32'(!busy));
            if (upd_valid && upd_ready && arb_on) acc_log.push_back(1'b0);
            if (lkp_valid && lkp_ready) begin
                exp_q.push_back('{r0: cur_exp0, r1: cur_exp1});
                if (arb_on) acc_log.push_back(1'b1);
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got r0=0x%0h r1=0x%0h, expected none", res_addr0, res_addr1);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk("res_addr0", res_addr0, e.r0);
                    chk("res_addr1", res_addr1, e.r1);
                end
            end
        end
    end

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n;
        @(posedge clk); #1;
        upd_addr  = a;
        upd_data  = d;
        upd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!upd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!upd_ready) begin
            fail("upd_accept");
            upd_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            upd_valid = 1'b0;
            upd_addr  = ~a;
            upd_data  = ~d;
            @(negedge clk);
            chk("wr_tcam_wr", tcam_wr, 1);
            chk("wr_tcam_addr", tcam_addr, a);
            chk("wr_tcam_data", tcam_data, d);
            chk("wr_busy", busy, 1);
            @(negedge clk);
            chk("wr_done_tcam_wr", tcam_wr, 0);
            chk("wr_hold_addr", tcam_addr, a);
            chk("wr_hold_data", tcam_data, d);
            chk("wr_done_busy", busy, 0);
        end
    endtask

    task automatic do_lookup(input logic [DATA_W-1:0] k, input logic [RES_W-1:0] e0,
                             input logic [RES_W-1:0] e1);
        int n;
        @(posedge clk); #1;
        lkp_key   = k;
        cur_exp0  = e0;
        cur_exp1  = e1;
        lkp_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!lkp_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!lkp_ready) begin
            fail("lkp_accept");
            lkp_valid = 1'b0;
        end else begin
            @(posedge clk); #1;               // accept edge E0
            lkp_valid = 1'b0;
            lkp_key   = ~k;
            @(negedge clk);
            chk("srch_tcam_wr", tcam_wr, 0);
            chk("srch_key", tcam_data, k);
            chk("srch_res_valid_early", res_valid, 0);
            @(negedge clk);
            chk("srch_key_held", tcam_data, k);
            chk("srch_res_valid_early", res_valid, 0);
            @(negedge clk);                   // after E0+2
            chk("res_valid_rise", res_valid, 1);
            @(negedge clk);
            chk("res_valid_fall", res_valid, 0);
            chk("lkp_done_busy", busy, 0);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || res_valid || exp_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy || res_valid || exp_q.size() != 0) fail("wait_idle");
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        reset = 1'b1;
`ifdef TCAM_CTRL_FLUSH_EN
        for (int i = 0; i < NENT; i++) begin
            @(negedge clk);
            chk("flush_wr", tcam_wr, 1);
            chk("flush_addr", tcam_addr, i);
            chk("flush_data", tcam_data, 0);
            chk("flush_busy", busy, 1);
            chk("flush_res_valid", res_valid, 0);
        end
        @(negedge clk);
        chk("post_flush_busy", busy, 0);
        chk("post_flush_upd_ready", upd_ready, 1);
        chk("post_flush_wr", tcam_wr, 0);
`else
        @(negedge clk);
        chk("rel_busy", busy, 0);
        chk("rel_upd_ready", upd_ready, 1);
        chk("rel_wr", tcam_wr, 0);
        chk("rel_res_valid", res_valid, 0);
`endif
    endtask

    typedef struct {
        bit                is_lkp;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [RES_W-1:0]  e0;
        logic [RES_W-1:0]  e1;
    } vec_t;

    vec_t vecs[13];
    bit   exp_order[10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        // Entry 4 already holds 0x04C and all other entries are 0 when the
        // table starts.
        vecs[0]  = '{1'b0, 4'd9,  10'h04C, 7'd0,   7'd0};
        vecs[1]  = '{1'b1, 4'd0,  10'h04C, 7'd4,   7'd9};
        vecs[2]  = '{1'b0, 4'd4,  10'h3FF, 7'd0,   7'd0};
        vecs[3]  = '{1'b1, 4'd0,  10'h04C, 7'd9,   7'd0};
        vecs[4]  = '{1'b1, 4'd0,  10'h3FF, 7'd4,   7'd0};
        vecs[5]  = '{1'b1, 4'd0,  10'h123, NO_HIT, 7'd0};
        vecs[6]  = '{1'b0, 4'd0,  10'h123, 7'd0,   7'd0};
        vecs[7]  = '{1'b0, 4'd15, 10'h123, 7'd0,   7'd0};
        vecs[8]  = '{1'b1, 4'd0,  10'h123, 7'd0,   7'd15};
        vecs[9]  = '{1'b1, 4'd0,  10'h000, 7'd1,   7'd2};
        vecs[10] = '{1'b0, 4'd1,  10'h2AA, 7'd0,   7'd0};
        vecs[11] = '{1'b1, 4'd0,  10'h000, 7'd2,   7'd3};
        vecs[12] = '{1'b1, 4'd0,  10'h2AA, 7'd1,   7'd0};
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1 init_mem = 1'b0;
        @(negedge clk);
        chk("rst_tcam_wr", tcam_wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_upd_ready", upd_ready, 0);
        chk("rst_lkp_ready", lkp_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_tcam_addr", tcam_addr, 0);
        chk("rst_tcam_data", tcam_data, 0);
        chk("rst_res_addr0", res_addr0, 0);
        chk("rst_res_addr1", res_addr1, 0);

`ifdef TCAM_CTRL_FLUSH_EN
        release_reset();
        do_write(4'd4, 10'b0001001100);
`else
        // An update presented at release is accepted at the first edge.
        upd_addr  = 4'd4;
        upd_data  = 10'b0001001100;
        upd_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rel_busy", busy, 0);
        chk("rel_upd_ready", upd_ready, 1);
        chk("rel_wr", tcam_wr, 0);
        @(posedge clk); #1;
        upd_valid = 1'b0;
        upd_data  = '0;
        @(negedge clk);
        chk("first_wr", tcam_wr, 1);
        chk("first_wr_addr", tcam_addr, 4);
        chk("first_wr_data", tcam_data, 10'h04C);
        chk("first_wr_busy", busy, 1);
        @(negedge clk);
        chk("first_wr_done", tcam_wr, 0);
        chk("first_wr_done_busy", busy, 0);
`endif

        // Lookup with result backpressure
        res_ready = 1'b0;
        @(posedge clk); #1;
        lkp_key   = 10'h04C;
        cur_exp0  = 7'd4;
        cur_exp1  = 7'd0;
        lkp_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!lkp_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!lkp_ready) begin
            fail("bp_lkp_accept");
            lkp_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            lkp_valid = 1'b0;
            @(negedge clk);
            chk("bp_res_valid_e0", res_valid, 0);
            @(negedge clk);
            chk("bp_res_valid_e1", res_valid, 0);
            @(negedge clk);
            chk("bp_res_valid_rise", res_valid, 1);
            chk("bp_res_addr0", res_addr0, 4);
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                chk("bp_res_valid_hold", res_valid, 1);
                chk("bp_res_addr0_hold", res_addr0, 4);
                chk("bp_res_addr1_hold", res_addr1, 0);
                chk("bp_upd_ready", upd_ready, 0);
                chk("bp_lkp_ready", lkp_ready, 0);
            end
            @(posedge clk); #1;
            res_ready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk("bp_res_valid_drop", res_valid, 0);
        end
        res_ready = 1'b1;
        wait_idle();

        // Table-driven updates and lookups
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_lkp) do_lookup(vecs[i].data, vecs[i].e0, vecs[i].e1);
            else                do_write(vecs[i].addr, vecs[i].data);
            wait_idle();
        end

        // Arbitration with both requesters continuously valid
        acc_log.delete();
        arb_on = 1'b1;
        @(posedge clk); #1;
        upd_addr  = 4'd12;
        upd_data  = 10'h0F0;
        upd_valid = 1'b1;
        lkp_key   = 10'h0F0;
        cur_exp0  = 7'd12;
        cur_exp1  = 7'd0;
        lkp_valid = 1'b1;
        n = 0;
        while (acc_log.size() < 10 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        upd_valid = 1'b0;
        lkp_valid = 1'b0;
        arb_on    = 1'b0;
        if (acc_log.size() < 10) begin
            fail("arb_accepts");
        end else begin
            for (int i = 0; i < 10; i++) chk($sformatf("arb_order[%0d]", i), 32'(acc_log[i]), 32'(exp_order[i]));
        end
        wait_idle();

        // Reset in the middle of a search
        @(posedge clk); #1;
        lkp_key   = 10'h0F0;
        cur_exp0  = 7'd12;
        cur_exp1  = 7'd0;
        lkp_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!lkp_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!lkp_ready) begin
            fail("rst_lkp_accept");
            lkp_valid = 1'b0;
        end else begin
            @(posedge clk); #1;              // E0
            lkp_valid = 1'b0;
            @(posedge clk); #1;              // E0+1
            reset = 1'b0;
            #1;
            exp_q.delete();
            chk("midrst_tcam_wr", tcam_wr, 0);
            chk("midrst_res_valid", res_valid, 0);
            chk("midrst_busy", busy, 0);
            chk("midrst_lkp_ready", lkp_ready, 0);
            chk("midrst_res_addr0", res_addr0, 0);
            repeat (2) @(posedge clk);
            release_reset();
        end
        reset = 1'b1;

        do_write(4'd3, 10'h155);
        wait_idle();
        do_lookup(10'h155, 7'd3, 7'd0);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
